// File: rtl/oflow_core_fsm_cr_if.sv
// Compare/fix handshake between the conflict-resolve scheduler and its datapath.
// master = scheduler side, slave = datapath side.
interface oflow_core_fsm_cr_if #(
  parameter int IDX_W = 7
);
  logic             pair_valid;
  logic [IDX_W-1:0] idx_a;
  logic [IDX_W-1:0] idx_b;
  logic             cmp_valid;
  logic             cmp_conflict;
  logic             fix_req;
  logic [IDX_W-1:0] fix_idx_a;
  logic [IDX_W-1:0] fix_idx_b;
  logic             fix_ack;

  modport master (
    output pair_valid, idx_a, idx_b, fix_req, fix_idx_a, fix_idx_b,
    input  cmp_valid, cmp_conflict, fix_ack
  );

  modport slave (
    input  pair_valid, idx_a, idx_b, fix_req, fix_idx_a, fix_idx_b,
    output cmp_valid, cmp_conflict, fix_ack
  );
endinterface

// File: rtl/oflow_core_fsm_cr.sv
// Conflict-resolve scheduler: one bbox-pair compare per cycle, stalls on ID conflicts until fixed.
// Registered outputs, first pair one cycle after start; fix_req is held until fix_ack.
module oflow_core_fsm_cr #(
  parameter int MAX_BBOX = 72,
  parameter int IDX_W    = 7,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset_N,
  input  logic                start_cr,
  input  logic [IDX_W:0]      num_of_bbox_in_frame,
  input  logic [CNT_W-1:0]    conflict_th,
  oflow_core_fsm_cr_if.master dp,
  output logic [CNT_W-1:0]    conflict_counter,
  output logic                conflict_counter_th,
  output logic                done_cr,
  output logic                busy
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_FIX, S_DONE} state_t;

  state_t           r_state, w_state_d;
  logic [IDX_W:0]   r_n, w_n_d;
  logic             r_pv, w_pv_d;
  logic [IDX_W-1:0] r_a, w_a_d, r_b, w_b_d;
  logic [IDX_W-1:0] r_pa, w_pa_d, r_pb, w_pb_d;
  logic             r_prev_vld;
  logic             r_fix, w_fix_d;
  logic [IDX_W-1:0] r_fa, w_fa_d, r_fb, w_fb_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_th, w_th_d;
  logic             r_done, w_done_d;
  logic             r_busy;

  logic [IDX_W:0]   w_n_clamp;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_conf, w_b_last, w_a_last, w_fix_last;

  assign w_n_clamp = (num_of_bbox_in_frame > (IDX_W+1)'(MAX_BBOX)) ?
                     (IDX_W+1)'(MAX_BBOX) : num_of_bbox_in_frame;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  // A result is only meaningful if a pair was actually issued in the previous cycle
  assign w_conf     = r_prev_vld & dp.cmp_valid & dp.cmp_conflict;
  assign w_b_last   = ({1'b0, r_b} == r_n - (IDX_W+1)'(1));
  assign w_a_last   = ({1'b0, r_a} == r_n - (IDX_W+1)'(2));
  assign w_fix_last = ({1'b0, r_fa} == r_n - (IDX_W+1)'(2)) &&
                      ({1'b0, r_fb} == r_n - (IDX_W+1)'(1));

  always_comb begin
    w_state_d = r_state;
    w_n_d     = r_n;
    w_pv_d    = 1'b0;
    w_a_d     = r_a;
    w_b_d     = r_b;
    w_pa_d    = r_pa;
    w_pb_d    = r_pb;
    w_fix_d   = 1'b0;
    w_fa_d    = r_fa;
    w_fb_d    = r_fb;
    w_cnt_d   = r_cnt;
    w_th_d    = r_th;
    w_done_d  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_cr) begin
          w_n_d   = w_n_clamp;
          w_cnt_d = '0;
          w_th_d  = 1'b0;
          if (w_n_clamp < (IDX_W+1)'(2)) begin
            w_state_d = S_DONE;
            w_done_d  = 1'b1;
          end else begin
            w_state_d = S_SCAN;
            w_pv_d    = 1'b1;
            w_a_d     = '0;
            w_b_d     = IDX_W'(1);
          end
        end
      end
      S_SCAN: begin
        if (w_conf) begin
          // Current pair is in flight and dropped; r_a/r_b keep it for reissue
          w_state_d = S_FIX;
          w_fix_d   = 1'b1;
          w_fa_d    = r_pa;
          w_fb_d    = r_pb;
        end else begin
          w_pa_d = r_a;
          w_pb_d = r_b;
          if (w_b_last) begin
            if (w_a_last) begin
              w_state_d = S_DRAIN;
            end else begin
              w_pv_d = 1'b1;
              w_a_d  = r_a + IDX_W'(1);
              w_b_d  = r_a + IDX_W'(2);
            end
          end else begin
            w_pv_d = 1'b1;
            w_b_d  = r_b + IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (w_conf) begin
          w_state_d = S_FIX;
          w_fix_d   = 1'b1;
          w_fa_d    = r_pa;
          w_fb_d    = r_pb;
        end else begin
          w_state_d = S_DONE;
          w_done_d  = 1'b1;
        end
      end
      S_FIX: begin
        w_fix_d = 1'b1;
        if (dp.fix_ack) begin
          w_fix_d = 1'b0;
          w_cnt_d = w_cnt_inc;
          if ((conflict_th != '0) && (w_cnt_inc == conflict_th)) begin
            w_th_d    = 1'b1;
            w_state_d = S_DONE;
            w_done_d  = 1'b1;
          end else if (w_fix_last) begin
            w_state_d = S_DONE;
            w_done_d  = 1'b1;
          end else begin
            w_state_d = S_SCAN;
            w_pv_d    = 1'b1;
          end
        end
      end
      S_DONE:  w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_N) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_pv       <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_pa       <= '0;
      r_pb       <= '0;
      r_prev_vld <= 1'b0;
      r_fix      <= 1'b0;
      r_fa       <= '0;
      r_fb       <= '0;
      r_cnt      <= '0;
      r_th       <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_n        <= w_n_d;
      r_pv       <= w_pv_d;
      r_a        <= w_a_d;
      r_b        <= w_b_d;
      r_pa       <= w_pa_d;
      r_pb       <= w_pb_d;
      r_prev_vld <= r_pv;
      r_fix      <= w_fix_d;
      r_fa       <= w_fa_d;
      r_fb       <= w_fb_d;
      r_cnt      <= w_cnt_d;
      r_th       <= w_th_d;
      r_done     <= w_done_d;
      r_busy     <= (w_state_d != S_IDLE);
    end
  end

  assign dp.pair_valid       = r_pv;
  assign dp.idx_a            = r_a;
  assign dp.idx_b            = r_b;
  assign dp.fix_req          = r_fix;
  assign dp.fix_idx_a        = r_fa;
  assign dp.fix_idx_b        = r_fb;
  assign conflict_counter    = r_cnt;
  assign conflict_counter_th = r_th;
  assign done_cr             = r_done;
  assign busy                = r_busy;

endmodule

// File: tb/tb_oflow_core_fsm_cr.sv
// Bench for oflow_core_fsm_cr: pair-list model of the scan/fix sequence, per-cycle compare,
// plus hand-computed pair/fix/done-cycle literals per scenario.
module tb_oflow_core_fsm_cr;
  localparam int NB = 72;

  logic       clk = 1'b0;
  logic       reset_N;
  logic       start_cr;
  logic [7:0] num;
  logic [7:0] conflict_th;
  logic [7:0] conflict_counter;
  logic       conflict_counter_th, done_cr, busy;

  oflow_core_fsm_cr_if #(.IDX_W(7)) dp_if ();

  oflow_core_fsm_cr dut (
    .clk                  (clk),
    .reset_N              (reset_N),
    .start_cr             (start_cr),
    .num_of_bbox_in_frame (num),
    .conflict_th          (conflict_th),
    .dp                   (dp_if),
    .conflict_counter     (conflict_counter),
    .conflict_counter_th  (conflict_counter_th),
    .done_cr              (done_cr),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pv; int a; int b; bit fr; int fa; int fb; bit dn; bit bz; int cnt; bit th;
  } exp_t;

  exp_t  q[$];
  bit    m_conf[NB][NB];
  bit    dp_conf[NB][NB];
  int    ack_d;
  bit    drop_valid;
  int    checks = 0;
  int    failures = 0;
  string cur;

  task automatic chk(input string nm, input int c, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s/%s cyc=%0d got=%0d exp=%0d", cur, nm, c, got, exp);
    end
  endtask

  task automatic emit(input bit pv, input int a, input int b, input bit fr, input int fa,
                      input int fb, input bit dn, input bit bz, input int cnt, input bit th);
    exp_t e;
    e.pv = pv; e.a = a; e.b = b; e.fr = fr; e.fa = fa; e.fb = fb;
    e.dn = dn; e.bz = bz; e.cnt = cnt; e.th = th;
    q.push_back(e);
  endtask

  // Walk the lexicographic pair list; a conflicting pair costs one wasted issue
  // (or the drain cycle) plus d+1 fix cycles, then the following pair is issued again.
  task automatic build(input int n_in, input int d, input int th);
    int n, cnt, i, last;
    bit thf, stop;
    int la[$], lb[$];
    q.delete();
    n = (n_in > NB) ? NB : n_in;
    cnt = 0; thf = 0; stop = 0;
    emit(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (n >= 2) begin
      for (int a = 0; a < n - 1; a++)
        for (int b = a + 1; b < n; b++) begin
          la.push_back(a); lb.push_back(b);
        end
      last = la.size() - 1;
      i = 0;
      while (i <= last && !stop) begin
        emit(1, la[i], lb[i], 0, 0, 0, 0, 1, cnt, thf);
        if (m_conf[la[i]][lb[i]]) begin
          if (i == last) emit(0, 0, 0, 0, 0, 0, 0, 1, cnt, thf);
          else           emit(1, la[i+1], lb[i+1], 0, 0, 0, 0, 1, cnt, thf);
          for (int k = 0; k <= d; k++) emit(0, 0, 0, 1, la[i], lb[i], 0, 1, cnt, thf);
          m_conf[la[i]][lb[i]] = 0;
          cnt = (cnt == 255) ? 255 : cnt + 1;
          if (th != 0 && cnt == th) begin thf = 1; stop = 1; end
          else if (i == last) stop = 1;
        end
        i++;
      end
      if (!stop) emit(0, 0, 0, 0, 0, 0, 0, 1, cnt, thf);
    end
    emit(0, 0, 0, 0, 0, 0, 1, 1, cnt, thf);
    emit(0, 0, 0, 0, 0, 0, 0, 0, cnt, thf);
  endtask

  task automatic clr_conf();
    for (int a = 0; a < NB; a++)
      for (int b = 0; b < NB; b++) begin m_conf[a][b] = 0; dp_conf[a][b] = 0; end
  endtask

  task automatic set_conf(input int a, input int b);
    m_conf[a][b] = 1; dp_conf[a][b] = 1;
  endtask

  task automatic set_all(input bit model_too);
    for (int a = 0; a < NB; a++)
      for (int b = 0; b < NB; b++) begin m_conf[a][b] = model_too; dp_conf[a][b] = 1; end
  endtask

  // Datapath stand-in: result one cycle after each issued pair, fix_ack d cycles after fix_req.
  initial begin
    int wcnt;
    bit pend_v, pend_c;
    wcnt = 0; pend_v = 0; pend_c = 0;
    dp_if.cmp_valid = 0; dp_if.cmp_conflict = 0; dp_if.fix_ack = 0;
    forever begin
      @(negedge clk);
      if (reset_N) begin
        wcnt = 0; pend_v = 0; pend_c = 0;
        dp_if.cmp_valid = 0; dp_if.cmp_conflict = 0; dp_if.fix_ack = 0;
      end else begin
        if (dp_if.fix_ack) begin
          dp_if.fix_ack = 0; wcnt = 0;
        end else if (dp_if.fix_req) begin
          if (wcnt == ack_d) begin
            dp_if.fix_ack = 1;
            dp_conf[dp_if.fix_idx_a][dp_if.fix_idx_b] = 0;
          end else wcnt++;
        end
        dp_if.cmp_valid    = pend_v & ~drop_valid;
        dp_if.cmp_conflict = pend_c;
        pend_v = dp_if.pair_valid;
        pend_c = dp_if.pair_valid ? dp_conf[dp_if.idx_a][dp_if.idx_b] : 1'b0;
      end
    end
  end

  task automatic run(input string nm, input int n, input int d, input int th, input int extra_start,
                     input int x_issues, input int x_fixes, input int x_done, input int x_cnt);
    int issues, fixes, done_c;
    bit prev_fr;
    exp_t e;
    cur = nm; issues = 0; fixes = 0; done_c = -1; prev_fr = 0;
    build(n, d, th);
    ack_d = d;
    @(negedge clk);
    num = 8'(n); conflict_th = 8'(th); start_cr = 1;
    for (int c = 1; c < q.size(); c++) begin
      @(negedge clk);
      start_cr = (c == extra_start);
      e = q[c];
      chk("pair_valid", c, dp_if.pair_valid, e.pv);
      if (e.pv) begin
        chk("idx_a", c, dp_if.idx_a, e.a);
        chk("idx_b", c, dp_if.idx_b, e.b);
      end
      chk("fix_req", c, dp_if.fix_req, e.fr);
      if (e.fr) begin
        chk("fix_idx_a", c, dp_if.fix_idx_a, e.fa);
        chk("fix_idx_b", c, dp_if.fix_idx_b, e.fb);
      end
      chk("done_cr", c, done_cr, e.dn);
      chk("busy", c, busy, e.bz);
      chk("conflict_counter", c, conflict_counter, e.cnt);
      chk("conflict_counter_th", c, conflict_counter_th, e.th);
      if (dp_if.pair_valid) issues++;
      if (dp_if.fix_req && !prev_fr) fixes++;
      prev_fr = dp_if.fix_req;
      if (done_cr && done_c < 0) done_c = c;
    end
    start_cr = 0;
    chk("lit_issues", -1, issues, x_issues);
    chk("lit_fixes", -1, fixes, x_fixes);
    chk("lit_done_cycle", -1, done_c, x_done);
    chk("lit_counter", -1, conflict_counter, x_cnt);
  endtask

  task automatic chk_all_zero(input string nm);
    cur = nm;
    chk("pair_valid", -1, dp_if.pair_valid, 0);
    chk("idx_a", -1, dp_if.idx_a, 0);
    chk("idx_b", -1, dp_if.idx_b, 0);
    chk("fix_req", -1, dp_if.fix_req, 0);
    chk("fix_idx_a", -1, dp_if.fix_idx_a, 0);
    chk("fix_idx_b", -1, dp_if.fix_idx_b, 0);
    chk("conflict_counter", -1, conflict_counter, 0);
    chk("conflict_counter_th", -1, conflict_counter_th, 0);
    chk("done_cr", -1, done_cr, 0);
    chk("busy", -1, busy, 0);
  endtask

  initial begin
    reset_N = 1; start_cr = 0; num = 0; conflict_th = 0;
    ack_d = 0; drop_valid = 0;
    clr_conf();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_N = 0;

    // Reset in the middle of a scan
    cur = "reset_mid_scan";
    @(negedge clk); num = 8; start_cr = 1;
    @(negedge clk); start_cr = 0;
    @(negedge clk);
    chk("pair_valid", -1, dp_if.pair_valid, 1);
    chk("busy", -1, busy, 1);
    reset_N = 1;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset_mid_scan");
    reset_N = 0;

    // Clean n=4 with junk conflict flags while cmp_valid stays low
    clr_conf(); set_all(0); drop_valid = 1;
    run("n4_clean_novalid", 4, 0, 0, -1, 6, 0, 8, 0);
    drop_valid = 0;

    clr_conf();
    run("n1", 1, 0, 0, -1, 0, 0, 1, 0);

    clr_conf(); set_conf(0, 2);
    run("n4_conf02", 4, 3, 0, -1, 7, 1, 13, 1);

    clr_conf(); set_all(1);
    run("n5_th2", 5, 1, 2, -1, 4, 2, 9, 2);
    cur = "n5_th2_hold";
    repeat (3) @(negedge clk);
    chk("th_held", -1, conflict_counter_th, 1);
    chk("cnt_held", -1, conflict_counter, 2);

    clr_conf(); set_conf(2, 3);
    run("n4_conf_last", 4, 2, 0, 9, 6, 1, 11, 1);

    clr_conf(); set_all(1);
    run("n4_all_conf", 4, 0, 0, -1, 11, 6, 19, 6);

    clr_conf();
    run("n72", 72, 0, 0, -1, 2556, 0, 2558, 0);

    clr_conf();
    run("n100_clamp", 100, 0, 0, -1, 2556, 0, 2558, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/oflow_core_fsm_cr.md
Name: oflow_core_fsm_cr

Overview:
Conflict-resolve scheduler for the oflow core. It is started by oflow_core_fsm_top via start_cr after registration. It sequences the conflict-resolve datapath over every unordered pair of bboxes in the current frame and issues one compare per cycle. When two bboxes claim the same ID it stalls and requests a fix. It counts fixes, raises conflict_counter_th when the programmed threshold is reached, and returns done_cr to oflow_core_fsm_top.

Parameters:
MAX_BBOX, 72, max bboxes per frame (PE_NUM*MAX_ROWS_IN_SCORE_BOARD)
IDX_W, 7, bbox index width, must hold MAX_BBOX-1
CNT_W, 8, conflict counter / threshold width

Ports:
clk  in  1  core clock
reset_N  in  1  synchronous reset, active-high (asserted = 1), sampled on rising clk
start_cr  in  1  single-cycle start pulse from oflow_core_fsm_top
num_of_bbox_in_frame  in  IDX_W+1  bbox count n, latched on accepted start
conflict_th  in  CNT_W  reg-file threshold; 0 = threshold disabled
pair_valid  out  1  compare request valid this cycle
idx_a  out  IDX_W  first bbox index of pair
idx_b  out  IDX_W  second bbox index of pair, always > idx_a
cmp_valid  in  1  datapath result valid, one cycle after pair_valid
cmp_conflict  in  1  result: both bboxes hold the same ID
fix_req  out  1  request datapath to resolve the conflicting pair
fix_idx_a  out  IDX_W  conflicting pair index a
fix_idx_b  out  IDX_W  conflicting pair index b
fix_ack  in  1  datapath done with fix, single-cycle pulse
conflict_counter  out  CNT_W  fixes performed this frame, saturating
conflict_counter_th  out  1  threshold reached; held until next accepted start
done_cr  out  1  single-cycle completion pulse
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset forces IDLE from any state, including mid-SCAN or mid-FIX. A pending fix is abandoned and fix_ack is ignored.
- States: IDLE, SCAN, DRAIN, FIX, DONE.
- IDLE:
  - start_cr=1: latch n, clear conflict_counter and conflict_counter_th.
  - If n<2, go to DONE. No pairs are issued.
  - Otherwise set (a,b)=(0,1) and go to SCAN.
  - start_cr in any other state is ignored.
- SCAN:
  - Drive pair_valid=1 with (idx_a,idx_b)=(a,b) each cycle.
  - Order: b increments; when b reaches n-1, a increments and b=a+1.
  - After issuing (n-2,n-1), go to DRAIN.
  - Keep the previous issued pair in prev registers.
- Result timing: the result for the pair issued in cycle t is visible at cycle t+1.
  - Results with cmp_conflict=0 are not acted on.
  - cmp_valid=0 while a result is expected is treated as no conflict.
- Conflict seen in SCAN at cycle t+1:
  - The pair issued in t+1 is in flight and must be discarded.
  - Go to FIX with fix pair = prev pair.
  - Rewind the pointer so the pair after the conflicting one is reissued.
  - Results arriving in FIX are ignored.
- DRAIN: one cycle, pair_valid=0. Conflict goes to FIX. Otherwise go to DONE.
- FIX:
  - Hold fix_req=1 and the fix indices stable until fix_ack=1.
  - On fix_ack, increment conflict_counter, saturating at 2^CNT_W-1.
  - If conflict_th!=0 and the new count == conflict_th: set conflict_counter_th=1 and go to DONE (abort the remaining pairs).
  - Else, if the fixed pair was (n-2,n-1), go to DONE.
  - Else return to SCAN, reissuing the rewound pair.
- fix_req drops in the cycle after fix_ack is sampled.
- DONE: done_cr=1 for exactly one cycle, then IDLE. conflict_counter and conflict_counter_th hold their values in IDLE.
- Pair count with no conflicts is n(n-1)/2. At n=72 this is 2556 compares.
- n > MAX_BBOX is clamped to MAX_BBOX.

Test Plan:
- Reset sequence: reset_N=1 for 2 cycles mid-SCAN -> all outputs 0, state IDLE; next start_cr accepted normally.
- n=1, start_cr at cycle 0 -> no pair_valid; done_cr=1 at cycle 1; conflict_counter=0.
- n=4, no conflicts, start at cycle 0:
  - pairs (0,1)(0,2)(0,3)(1,2)(1,3)(2,3) on cycles 1-6; DRAIN at cycle 7; done_cr at cycle 8.
- n=4, conflict on (0,2), fix_ack 3 cycles after fix_req:
  - fix_idx=(0,2); the in-flight (0,3) result is ignored; (0,3) is reissued after FIX.
  - Remaining pairs follow in order; conflict_counter=1; done_cr pulses once.
- n=5, conflict_th=2, every pair conflicts:
  - after the 2nd fix_ack: conflict_counter=2, conflict_counter_th=1, done_cr.
  - Only (0,1) and (0,2) were fixed; conflict_counter_th stays 1 until the next start.
- Conflict on the last pair (2,3), n=4 -> FIX from DRAIN, then done_cr; start_cr pulsed during FIX is ignored.
